dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters SHALL be: DEPTH_WORDS, default 128, number of 32-bit memory words; LATENCY, default 2, number of wait cycles between request acceptance and response (legal 1..15).
REQ-002 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, synchronous active-high reset.
REQ-004 Port req_valid, input, 1, the CPU presents a memory request.
REQ-005 Port req_ready, output, 1, the responder can accept a request this cycle.
REQ-006 Port req_we, input, 1, 1 = store, 0 = load.
REQ-007 Port req_addr, input, 32, byte address.
REQ-008 Port req_wdata, input, 32, store data, right-aligned.
REQ-009 Port req_dmtype, input, 3, access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned.
REQ-010 Port resp_valid, output, 1, response available.
REQ-011 Port resp_ready, input, 1, the CPU accepts the response.
REQ-012 Port resp_rdata, output, 32, load data, extended per dmtype; 0 for stores and errors.
REQ-013 Port resp_err, output, 1, misaligned, out-of-range or illegal-dmtype request.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid && req_ready.
REQ-016 On acceptance, addr, we, wdata and dmtype SHALL be latched, the wait counter loaded with LATENCY-1, and the state set to WAIT.
REQ-017 In WAIT the counter SHALL decrement each cycle; at zero the state SHALL become RESP, giving resp_valid exactly LATENCY cycles after acceptance.
REQ-018 In RESP, resp_valid, resp_rdata and resp_err SHALL stay stable until resp_valid && resp_ready; the state then returns to IDLE, and no new request is accepted in that same cycle.
REQ-019 A store SHALL commit to the array only on the WAIT-to-RESP transition, using byte enables: word 1111; half 0011 or 1100 by addr[1]; byte one-hot by addr[1:0]. Lanes are taken from the low bits of wdata, shifted to the lane.
REQ-020 Load data SHALL be read on the WAIT-to-RESP transition, shifted down by the address offset, then sign- or zero-extended per dmtype.
REQ-021 The request SHALL be an error when any of these holds: word with addr[1:0] != 0; half with addr[0] = 1; dmtype > 100; addr[31:2] >= DEPTH_WORDS.
REQ-022 An erroring request SHALL be treated as follows: no array write; resp_err = 1; resp_rdata = 0; same latency as a good request.
REQ-023 The word index SHALL be addr[31:2]; bits above clog2(DEPTH_WORDS) SHALL be used only for the range check, never wrapped.
REQ-024 A request changing while req_ready = 0 SHALL be ignored; the latched copy alone defines the in-flight transaction.

Reset
REQ-025 On reset the state SHALL return to IDLE, the counter to 0, and the outputs to: req_ready = 1 from the first post-reset cycle, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-026 Reset asserted during WAIT SHALL abort the transaction with no array write; reset during RESP SHALL drop the response.
REQ-027 Memory array contents SHALL NOT be cleared by reset.

Structure
REQ-028 The dmtype encodings and the FSM state encoding SHALL live in the shared CPU package so that the CPU memory stage and this block use one definition.
REQ-029 The byte-enable generation and the load extraction/extension SHALL form one combinational sub-module, dm_lane_align, instantiated once.

Verification
REQ-030 Store word 0x12345678 at 0x10, then load word at 0x10 -> resp_rdata = 0x12345678, resp_err = 0, resp_valid exactly 2 cycles after each acceptance.
REQ-031 Store byte 0xAB at 0x13 over 0x12345678, then load byte signed at 0x13 -> 0xFFFFFFAB; load byte unsigned -> 0x000000AB; load word -> 0xAB345678.
REQ-032 Load word at 0x12, then store half at 0x11 -> resp_err = 1 and resp_rdata = 0 for both; the word at 0x10 is unchanged.
REQ-033 Store to 0x200 with DEPTH_WORDS = 128 -> resp_err = 1; the array is unchanged.
REQ-034 Hold resp_ready = 0 for 5 cycles in RESP -> response stays stable, req_ready = 0 throughout, a new req_valid is not accepted; accepted in the cycle after the handshake.
REQ-035 Assert reset for 1 cycle during WAIT of store 0xDEADBEEF to 0x20 -> resp_valid never rises, a later load of 0x20 returns the old value, req_ready = 1 after reset.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared CPU memory-stage definitions: access types, responder FSM states
// and the request legality check used by both the CPU and the responder.
package dmem_responder_pkg;

  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF_S = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE_S = 3'b011,
    DM_BYTE_U = 3'b100
  } dm_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmem_state_e;

  // True when the access type is unknown or the offset breaks natural alignment
  function automatic logic dm_bad_access(input logic [2:0] dmtype, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (dmtype)
      DM_WORD:              bad = (offset != 2'b00);
      DM_HALF_S, DM_HALF_U: bad = offset[0];
      DM_BYTE_S, DM_BYTE_U: bad = 1'b0;
      default:              bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for the data memory: store byte enables and lane
// placement, plus load extraction with sign/zero extension.
module dm_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  dmtype,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  // Store side: replicate the low bits of wdata across lanes, enable only the target lanes
  always_comb begin
    be    = 4'b0000;
    wword = wdata;
    case (dmtype)
      DM_WORD: begin
        be    = 4'b1111;
        wword = wdata;
      end
      DM_HALF_S, DM_HALF_U: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wword = {wdata[15:0], wdata[15:0]};
      end
      DM_BYTE_S, DM_BYTE_U: begin
        be    = 4'b0001 << offset;
        wword = {4{wdata[7:0]}};
      end
      default: begin
        be    = 4'b0000;
        wword = wdata;
      end
    endcase
  end

  // Load side: move the addressed lane down to bit 0, then extend per access type
  always_comb begin
    shifted = rword >> {offset, 3'b000};
    rdata   = 32'h0;
    case (dmtype)
      DM_WORD:   rdata = rword;
      DM_HALF_S: rdata = {{16{shifted[15]}}, shifted[15:0]};
      DM_HALF_U: rdata = {16'h0, shifted[15:0]};
      DM_BYTE_S: rdata = {{24{shifted[7]}}, shifted[7:0]};
      DM_BYTE_U: rdata = {24'h0, shifted[7:0]};
      default:   rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time, waits LATENCY
// cycles, commits stores / reads loads, then holds the response until taken.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_dmtype,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  dmtype_q, dmtype_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        commit;

  logic [31:0] mem [DEPTH_WORDS];

  logic             out_of_range;
  logic             req_err;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wword;
  logic [31:0]      load_data;

  // Upper address bits only feed the range check; the array index never wraps
  assign out_of_range = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
  assign req_err      = out_of_range | dm_bad_access(dmtype_q, addr_q[1:0]);
  assign idx          = addr_q[IDX_W+1:2];

  dm_lane_align u_lane_align (
    .dmtype (dmtype_q),
    .offset (addr_q[1:0]),
    .wdata  (wdata_q),
    .rword  (mem[idx]),
    .be     (be),
    .wword  (wword),
    .rdata  (load_data)
  );

  // Next-state, latch and handshake logic; defaults hold everything
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    dmtype_d   = dmtype_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    commit     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d   = req_addr;
          we_d     = req_we;
          wdata_d  = req_wdata;
          dmtype_d = req_dmtype;
          cnt_d    = CNT_LOAD;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          err_d   = req_err;
          rdata_d = (req_err || we_q) ? 32'h0 : load_data;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and transaction registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'h0;
      we_q     <= 1'b0;
      wdata_q  <= 32'h0;
      dmtype_q <= 3'b000;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      dmtype_q <= dmtype_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Array write at the end of the wait; reset aborts it and never clears contents
  always_ff @(posedge clk) begin
    if (!reset && commit && we_q && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][i*8 +: 8] <= wword[i*8 +: 8];
        end
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
